// File: rtl/market_record_assembler.sv
// rtl/market_record_assembler.sv - packs FIFO bytes into 8-byte order records, checks packet index sequence.
// Optional partial-record idle timeout is compiled in with MARKET_RECORD_TIMEOUT_EN.
module market_record_assembler #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       fifo_dout,
    input  logic             fifo_empty,
    output logic             fifo_rd_en,
    input  logic [11:0]      rx_index_in,
    input  logic             rx_packet_tlast_pulse,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [7:0]       m_type,
    output logic [23:0]      m_price,
    output logic [15:0]      m_qty,
    output logic [15:0]      m_order_id,
    input  logic             clear_stats,
    output logic             seq_error,
    output logic [CNT_W-1:0] gap_count,
    output logic [CNT_W-1:0] bad_record_count,
    output logic [CNT_W-1:0] timeout_count
);
    typedef enum logic {COLLECT, EMIT} state_t;

    state_t      state_q, state_d;
    logic [3:0]  req_cnt_q, req_cnt_d;
    logic [3:0]  got_cnt_q, got_cnt_d;
    logic        rd_pending_q;
    logic [63:0] buf_q, buf_d;
    logic [7:0]  type_q, type_d;
    logic [23:0] price_q, price_d;
    logic [15:0] qty_q, qty_d;
    logic [15:0] oid_q, oid_d;
    logic        bad_inc, tmo_inc, tmo_fire;
    logic [11:0] exp_q;
    logic        exp_valid_q, seq_err_q;
    logic [CNT_W-1:0] gap_q, bad_q;
    logic        mismatch;

`ifdef MARKET_RECORD_TIMEOUT_EN
    localparam int IW = $clog2(TIMEOUT_CYCLES + 1);
    logic [IW-1:0]    idle_q;
    logic [CNT_W-1:0] tmo_q;

    // rd_pending blocks the timeout so an in-flight byte lands and restarts the count
    assign tmo_fire = (state_q == COLLECT) && (got_cnt_q != 4'd0) && !rd_pending_q
                      && (idle_q == IW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_q <= '0;
            tmo_q  <= '0;
        end else begin
            if (state_q == COLLECT && got_cnt_q != 4'd0 && !rd_pending_q && !tmo_fire)
                idle_q <= idle_q + 1'b1;
            else
                idle_q <= '0;
            if (clear_stats)
                tmo_q <= '0;
            else if (tmo_inc && !(&tmo_q))
                tmo_q <= tmo_q + 1'b1;
        end
    end
    assign timeout_count = tmo_q;
`else
    assign tmo_fire      = 1'b0;
    assign timeout_count = '0;
`endif

    always_comb begin
        state_d    = state_q;
        req_cnt_d  = req_cnt_q;
        got_cnt_d  = got_cnt_q;
        buf_d      = buf_q;
        type_d     = type_q;
        price_d    = price_q;
        qty_d      = qty_q;
        oid_d      = oid_q;
        fifo_rd_en = 1'b0;
        bad_inc    = 1'b0;
        tmo_inc    = 1'b0;
        case (state_q)
            COLLECT: begin
                fifo_rd_en = !fifo_empty && (req_cnt_q < 4'd8) && !tmo_fire;
                if (fifo_rd_en)
                    req_cnt_d = req_cnt_q + 4'd1;
                if (rd_pending_q) begin
                    buf_d[{got_cnt_q[2:0], 3'b000} +: 8] = fifo_dout;
                    got_cnt_d = got_cnt_q + 4'd1;
                    if (got_cnt_q == 4'd7) begin
                        req_cnt_d = 4'd0;
                        got_cnt_d = 4'd0;
                        if (buf_d[7:0] >= 8'h01 && buf_d[7:0] <= 8'h03) begin
                            type_d  = buf_d[7:0];
                            price_d = {buf_d[15:8], buf_d[23:16], buf_d[31:24]};
                            qty_d   = {buf_d[39:32], buf_d[47:40]};
                            oid_d   = {buf_d[55:48], buf_d[63:56]};
                            state_d = EMIT;
                        end else begin
                            bad_inc = 1'b1;
                        end
                    end
                end
                if (tmo_fire) begin
                    req_cnt_d = 4'd0;
                    got_cnt_d = 4'd0;
                    tmo_inc   = 1'b1;
                end
            end
            EMIT: begin
                if (m_ready)
                    state_d = COLLECT;
            end
            default: state_d = COLLECT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= COLLECT;
            req_cnt_q    <= 4'd0;
            got_cnt_q    <= 4'd0;
            rd_pending_q <= 1'b0;
            buf_q        <= '0;
            type_q       <= '0;
            price_q      <= '0;
            qty_q        <= '0;
            oid_q        <= '0;
        end else begin
            state_q      <= state_d;
            req_cnt_q    <= req_cnt_d;
            got_cnt_q    <= got_cnt_d;
            rd_pending_q <= fifo_rd_en;
            buf_q        <= buf_d;
            type_q       <= type_d;
            price_q      <= price_d;
            qty_q        <= qty_d;
            oid_q        <= oid_d;
        end
    end

    assign mismatch = rx_packet_tlast_pulse && exp_valid_q && (rx_index_in != exp_q);

    // clear_stats takes priority over any same-cycle increment
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_q       <= '0;
            exp_valid_q <= 1'b0;
            seq_err_q   <= 1'b0;
            gap_q       <= '0;
            bad_q       <= '0;
        end else if (clear_stats) begin
            exp_valid_q <= 1'b0;
            seq_err_q   <= 1'b0;
            gap_q       <= '0;
            bad_q       <= '0;
        end else begin
            if (rx_packet_tlast_pulse) begin
                exp_q       <= rx_index_in + 12'd1;
                exp_valid_q <= 1'b1;
            end
            if (mismatch) begin
                seq_err_q <= 1'b1;
                if (!(&gap_q))
                    gap_q <= gap_q + 1'b1;
            end
            if (bad_inc && !(&bad_q))
                bad_q <= bad_q + 1'b1;
        end
    end

    assign m_valid          = (state_q == EMIT);
    assign m_type           = type_q;
    assign m_price          = price_q;
    assign m_qty            = qty_q;
    assign m_order_id       = oid_q;
    assign seq_error        = seq_err_q;
    assign gap_count        = gap_q;
    assign bad_record_count = bad_q;
endmodule

// File: tb/tb_market_record_assembler.sv
// tb/tb_market_record_assembler.sv - directed self-checking bench for market_record_assembler.
module tb_market_record_assembler;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    fifo_dout = 8'h00;
    logic          fifo_empty = 1'b1;
    logic          fifo_rd_en;
    logic [11:0]   rx_index_in = 12'h000;
    logic          rx_packet_tlast_pulse = 1'b0;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [7:0]    m_type;
    logic [23:0]   m_price;
    logic [15:0]   m_qty;
    logic [15:0]   m_order_id;
    logic          clear_stats = 1'b0;
    logic          seq_error;
    logic [CW-1:0] gap_count;
    logic [CW-1:0] bad_record_count;
    logic [CW-1:0] timeout_count;

    int total = 0;
    int bad = 0;

    logic [7:0]  fq[$];
    logic [63:0] rx[$];
    int rd_total = 0;
    int run = 0;
    int max_run = 0;

    market_record_assembler #(.TIMEOUT_CYCLES(16), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .fifo_dout(fifo_dout), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
        .rx_index_in(rx_index_in), .rx_packet_tlast_pulse(rx_packet_tlast_pulse),
        .m_valid(m_valid), .m_ready(m_ready), .m_type(m_type), .m_price(m_price),
        .m_qty(m_qty), .m_order_id(m_order_id), .clear_stats(clear_stats),
        .seq_error(seq_error), .gap_count(gap_count),
        .bad_record_count(bad_record_count), .timeout_count(timeout_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (fifo_rd_en && fq.size() > 0)
            fifo_dout <= fq.pop_front();
        fifo_empty <= (fq.size() == 0);
    end

    always @(negedge clk) begin
        if (m_valid && m_ready)
            rx.push_back({m_type, m_price, m_qty, m_order_id});
        if (fifo_rd_en) begin
            rd_total++;
            run++;
            if (run > max_run) max_run = run;
        end else begin
            run = 0;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push8(input logic [63:0] r);
        for (int i = 7; i >= 0; i--)
            fq.push_back(r[i*8 +: 8]);
    endtask

    task automatic wait_rx(input int n);
        for (int i = 0; i < 200; i++) begin
            if (rx.size() >= n) break;
            tick(1);
        end
        chk("rx_count", 64'(rx.size()), 64'(n));
    endtask

    task automatic pulse(input logic [11:0] idx);
        rx_index_in = idx;
        rx_packet_tlast_pulse = 1'b1;
        tick(1);
        rx_packet_tlast_pulse = 1'b0;
    endtask

    initial begin
        int snap;
        tick(3);
        chk("rst_valid", 64'(m_valid), 64'd0);
        chk("rst_rd_en", 64'(fifo_rd_en), 64'd0);
        chk("rst_fields", {m_type, m_price, m_qty, m_order_id}, 64'd0);
        chk("rst_stats", {seq_error, gap_count, bad_record_count, timeout_count}, 64'd0);
        rst = 1'b0;
        tick(2);

        // single record
        m_ready = 1'b1;
        rd_total = 0; max_run = 0;
        push8(64'h01_00_12_34_00_0A_00_07);
        wait_rx(1);
        if (rx.size() >= 1) chk("single_rec", rx[0], 64'h01_001234_000A_0007);
        tick(3);
        chk("single_rd_total", 64'(rd_total), 64'd8);
        chk("single_rd_run", 64'(max_run), 64'd8);
        chk("single_one_rec", 64'(rx.size()), 64'd1);

        // backpressure
        m_ready = 1'b0;
        push8(64'h02_00_00_64_00_05_00_01);
        push8(64'h03_AB_CD_EF_12_34_56_78);
        for (int i = 0; i < 100 && !m_valid; i++) tick(1);
        chk("bp_valid_up", 64'(m_valid), 64'd1);
        snap = rd_total;
        tick(20);
        chk("bp_no_reads", 64'(rd_total - snap), 64'd0);
        chk("bp_held", {m_valid, m_type, m_price, m_qty, m_order_id}, {1'b1, 64'h02_000064_0005_0001});
        m_ready = 1'b1;
        wait_rx(3);
        if (rx.size() >= 3) begin
            chk("bp_rec1", rx[1], 64'h02_000064_0005_0001);
            chk("bp_rec2", rx[2], 64'h03_ABCDEF_1234_5678);
        end

        // bad type followed by a sell
        push8(64'h7F_01_02_03_04_05_06_07);
        push8(64'h02_00_01_00_00_02_00_09);
        wait_rx(4);
        tick(3);
        chk("bad_cnt", 64'(bad_record_count), 64'd1);
        chk("bad_one_rec", 64'(rx.size()), 64'd4);
        if (rx.size() >= 4) chk("bad_sell_rec", rx[3], 64'h02_000100_0002_0009);

        // sequence check
        pulse(12'h005); pulse(12'h006); pulse(12'h008); pulse(12'hFFF); pulse(12'h000);
        tick(1);
        chk("seq_gap", 64'(gap_count), 64'd2);
        chk("seq_err", 64'(seq_error), 64'd1);
        clear_stats = 1'b1; tick(1); clear_stats = 1'b0; tick(1);
        chk("seq_clear", {seq_error, gap_count, bad_record_count}, 64'd0);

        // saturation then clear precedence
        rx_index_in = 12'h000;
        rx_packet_tlast_pulse = 1'b1;
        tick(300);
        rx_packet_tlast_pulse = 1'b0;
        tick(1);
        chk("sat_gap", 64'(gap_count), 64'hFF);
        pulse(12'h000);
        chk("sat_hold", 64'(gap_count), 64'hFF);
        clear_stats = 1'b1;
        pulse(12'h000);
        clear_stats = 1'b0;
        chk("clr_wins", {seq_error, gap_count}, 64'd0);
        pulse(12'h123);
        chk("clr_first_ok", {seq_error, gap_count}, 64'd0);

        // truncated record then a full one
        fq.push_back(8'h02); fq.push_back(8'h11); fq.push_back(8'h22);
        tick(40);
        push8(64'h01_00_00_10_00_01_00_02);
        wait_rx(5);
`ifdef MARKET_RECORD_TIMEOUT_EN
        chk("tmo_cnt", 64'(timeout_count), 64'd1);
        if (rx.size() >= 5) chk("tmo_aligned", rx[4], 64'h01_000010_0001_0002);
`else
        chk("tmo_cnt", 64'(timeout_count), 64'd0);
        if (rx.size() >= 5) chk("tmo_misaligned", rx[4], 64'h02_112201_0000_1000);
`endif

        // asynchronous reset drops m_valid immediately
        m_ready = 1'b0;
        push8(64'h01_00_00_01_00_01_00_01);
        for (int i = 0; i < 100 && !m_valid; i++) tick(1);
        chk("ar_valid_up", 64'(m_valid), 64'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("ar_valid_drop", 64'(m_valid), 64'd0);
        tick(2);
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
